// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/load-store arbiter onto one single-ported memory
// Data wins by default; a saturating wait counter forces fetch through after MAX_WAIT lost cycles.
module mem_port_arbiter #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_req_i,
  input  logic [63:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [63:0] instr_rdata_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [63:0] data_addr_i,
  input  logic [63:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [63:0] data_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [63:0] mem_addr_o,
  output logic [63:0] mem_wdata_o,
  input  logic [63:0] mem_rdata_i,
  output logic [15:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    RESP_NONE,
    RESP_INSTR,
    RESP_DATA
  } resp_state_e;

  resp_state_e state_q, state_d;
  logic [3:0]  wait_cnt;
  logic        fetch_forced;
  logic        stalled;

  assign fetch_forced = (wait_cnt == 4'(MAX_WAIT));
  assign instr_gnt_o  = instr_req_i & (~data_req_i | fetch_forced);
  assign data_gnt_o   = data_req_i & ~instr_gnt_o;
  assign mem_req_o    = instr_gnt_o | data_gnt_o;

  always_comb begin
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = 64'h0;
    mem_wdata_o = 64'h0;
    if (instr_gnt_o) begin
      mem_addr_o = instr_addr_i;
    end else if (data_gnt_o) begin
      mem_we_o    = data_we_i;
      mem_be_o    = data_be_i;
      mem_addr_o  = data_addr_i;
      mem_wdata_o = data_wdata_i;
    end
  end

  // A grant this cycle always wins over saturation: the counter clears.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_cnt <= 4'h0;
    end else if (!instr_req_i || instr_gnt_o) begin
      wait_cnt <= 4'h0;
    end else if (!fetch_forced) begin
      wait_cnt <= wait_cnt + 4'h1;
    end
  end

  assign stalled = (instr_req_i & ~instr_gnt_o) | (data_req_i & ~data_gnt_o);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_o <= 16'h0;
    end else if (stalled && stall_cnt_o != 16'hFFFF) begin
      stall_cnt_o <= stall_cnt_o + 16'h1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RESP_NONE;
    end else begin
      state_q <= state_d;
    end
  end

  // Response owner is just last cycle's grant, so back-to-back requests stream.
  always_comb begin
    state_d        = RESP_NONE;
    instr_rvalid_o = 1'b0;
    data_rvalid_o  = 1'b0;
    instr_rdata_o  = 64'h0;
    data_rdata_o   = 64'h0;
    if (instr_gnt_o) begin
      state_d = RESP_INSTR;
    end else if (data_gnt_o) begin
      state_d = RESP_DATA;
    end
    case (state_q)
      RESP_INSTR: begin
        instr_rvalid_o = 1'b1;
        instr_rdata_o  = mem_rdata_i;
      end
      RESP_DATA: begin
        data_rvalid_o = 1'b1;
        data_rdata_o  = mem_rdata_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
// Inputs change at the falling edge; outputs are checked 1 ns later.
module tb_mem_port_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        instr_req_i;
  logic [63:0] instr_addr_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic [63:0] instr_rdata_o;
  logic        data_req_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [63:0] data_addr_i;
  logic [63:0] data_wdata_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic [63:0] data_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [63:0] mem_addr_o;
  logic [63:0] mem_wdata_o;
  logic [63:0] mem_rdata_i;
  logic [15:0] stall_cnt_o;

  int n_assert = 0;
  int n_fail   = 0;

  mem_port_arbiter #(.MAX_WAIT(4)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .instr_req_i    (instr_req_i),
    .instr_addr_i   (instr_addr_i),
    .instr_gnt_o    (instr_gnt_o),
    .instr_rvalid_o (instr_rvalid_o),
    .instr_rdata_o  (instr_rdata_o),
    .data_req_i     (data_req_i),
    .data_we_i      (data_we_i),
    .data_be_i      (data_be_i),
    .data_addr_i    (data_addr_i),
    .data_wdata_i   (data_wdata_i),
    .data_gnt_o     (data_gnt_o),
    .data_rvalid_o  (data_rvalid_o),
    .data_rdata_o   (data_rdata_o),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_be_o       (mem_be_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_rdata_i    (mem_rdata_i),
    .stall_cnt_o    (stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_i);
  endtask

  initial begin
    rst_ni = 1'b0;
    instr_req_i = 1'b0; instr_addr_i = 64'h0;
    data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = 4'h0;
    data_addr_i = 64'h0; data_wdata_i = 64'h0;
    mem_rdata_i = 64'hA5A5_A5A5_A5A5_A5A5;

    // reset state
    step(); step();
    #1;
    chk("rst_stall", 64'(stall_cnt_o), 64'h0);
    chk("rst_instr_rvalid", 64'(instr_rvalid_o), 64'h0);
    chk("rst_data_rvalid", 64'(data_rvalid_o), 64'h0);
    chk("rst_instr_rdata", instr_rdata_o, 64'h0);
    chk("rst_data_rdata", data_rdata_o, 64'h0);
    chk("idle_mem_req", 64'(mem_req_o), 64'h0);
    step(); rst_ni = 1'b1;

    // single fetch; data-side attributes are junk and must not leak
    step();
    instr_req_i = 1'b1; instr_addr_i = 64'h1000;
    data_we_i = 1'b1; data_be_i = 4'hF; data_addr_i = 64'h9999; data_wdata_i = 64'h1234;
    #1;
    chk("f_gnt", 64'(instr_gnt_o), 64'h1);
    chk("f_dgnt", 64'(data_gnt_o), 64'h0);
    chk("f_mem_req", 64'(mem_req_o), 64'h1);
    chk("f_mem_addr", mem_addr_o, 64'h1000);
    chk("f_mem_we", 64'(mem_we_o), 64'h0);
    chk("f_mem_be", 64'(mem_be_o), 64'h0);
    chk("f_mem_wdata", mem_wdata_o, 64'h0);
    chk("f_rdata_gated", instr_rdata_o, 64'h0);
    step();
    instr_req_i = 1'b0; mem_rdata_i = 64'h0000_0013_0000_0013;
    #1;
    chk("f_rvalid", 64'(instr_rvalid_o), 64'h1);
    chk("f_rdata", instr_rdata_o, 64'h0000_0013_0000_0013);
    chk("f_no_drvalid", 64'(data_rvalid_o), 64'h0);
    chk("f_idle_mem_addr", mem_addr_o, 64'h0);
    step();
    #1;
    chk("f_rvalid_once", 64'(instr_rvalid_o), 64'h0);

    // store then load back-to-back
    step();
    data_req_i = 1'b1; data_we_i = 1'b1; data_be_i = 4'hF;
    data_addr_i = 64'h2000; data_wdata_i = 64'hDEAD_BEEF;
    #1;
    chk("st_gnt", 64'(data_gnt_o), 64'h1);
    chk("st_we", 64'(mem_we_o), 64'h1);
    chk("st_be", 64'(mem_be_o), 64'hF);
    chk("st_wdata", mem_wdata_o, 64'hDEAD_BEEF);
    chk("st_addr", mem_addr_o, 64'h2000);
    step();
    data_we_i = 1'b0; data_be_i = 4'h0; data_wdata_i = 64'h0; mem_rdata_i = 64'h11;
    #1;
    chk("ld_gnt", 64'(data_gnt_o), 64'h1);
    chk("ld_we", 64'(mem_we_o), 64'h0);
    chk("st_rvalid", 64'(data_rvalid_o), 64'h1);
    chk("st_rdata", data_rdata_o, 64'h11);
    step();
    data_req_i = 1'b0; mem_rdata_i = 64'hDEAD_BEEF;
    #1;
    chk("ld_rvalid", 64'(data_rvalid_o), 64'h1);
    chk("ld_rdata", data_rdata_o, 64'hDEAD_BEEF);
    step();
    #1;
    chk("ld_rvalid_once", 64'(data_rvalid_o), 64'h0);
    chk("no_stall_yet", 64'(stall_cnt_o), 64'h0);

    // conflict: data first, fetch next cycle
    step();
    instr_req_i = 1'b1; instr_addr_i = 64'h3000;
    data_req_i = 1'b1; data_addr_i = 64'h4000;
    #1;
    chk("c_dgnt", 64'(data_gnt_o), 64'h1);
    chk("c_igate", 64'(instr_gnt_o), 64'h0);
    chk("c_addr", mem_addr_o, 64'h4000);
    step();
    data_req_i = 1'b0;
    #1;
    chk("c_igant", 64'(instr_gnt_o), 64'h1);
    chk("c_addr2", mem_addr_o, 64'h3000);
    chk("c_drvalid", 64'(data_rvalid_o), 64'h1);
    chk("c_stall", 64'(stall_cnt_o), 64'h1);
    step();
    instr_req_i = 1'b0;
    #1;
    chk("c_irvalid", 64'(instr_rvalid_o), 64'h1);
    chk("c_drvalid_off", 64'(data_rvalid_o), 64'h0);

    // starvation guard: forced fetch in cycles 5 and 10 of a continuous conflict
    step();
    instr_req_i = 1'b1; instr_addr_i = 64'h6000;
    data_req_i = 1'b1; data_addr_i = 64'h5000;
    for (int i = 1; i <= 10; i++) begin
      #1;
      chk($sformatf("sv_igant_%0d", i), 64'(instr_gnt_o), ((i == 5) || (i == 10)) ? 64'h1 : 64'h0);
      chk($sformatf("sv_dgnt_%0d", i), 64'(data_gnt_o), ((i == 5) || (i == 10)) ? 64'h0 : 64'h1);
      chk($sformatf("sv_addr_%0d", i), mem_addr_o, ((i == 5) || (i == 10)) ? 64'h6000 : 64'h5000);
      step();
    end
    instr_req_i = 1'b0; data_req_i = 1'b0;
    #1;
    chk("sv_irvalid", 64'(instr_rvalid_o), 64'h1);
    chk("sv_stall", 64'(stall_cnt_o), 64'd11);

    // reset asserted in the cycle of a data grant drops its response
    step();
    data_req_i = 1'b1; data_addr_i = 64'h7000;
    #1;
    chk("r_dgnt", 64'(data_gnt_o), 64'h1);
    #1;
    rst_ni = 1'b0; data_req_i = 1'b0;
    step();
    #1;
    chk("r_drvalid", 64'(data_rvalid_o), 64'h0);
    chk("r_stall", 64'(stall_cnt_o), 64'h0);
    chk("r_drdata", data_rdata_o, 64'h0);
    step(); rst_ni = 1'b1;
    step();
    #1;
    chk("r_post_drvalid", 64'(data_rvalid_o), 64'h0);
    chk("r_post_irvalid", 64'(instr_rvalid_o), 64'h0);

    // stall counter saturation
    step();
    instr_req_i = 1'b1; data_req_i = 1'b1;
    repeat (65534) @(posedge clk_i);
    #1;
    chk("sat_below", 64'(stall_cnt_o), 64'hFFFE);
    repeat (6) @(posedge clk_i);
    #1;
    chk("sat_hold", 64'(stall_cnt_o), 64'hFFFF);
    step();
    instr_req_i = 1'b0; data_req_i = 1'b0;
    step();
    #1;
    chk("sat_idle", 64'(stall_cnt_o), 64'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
